sevenseg_scan: RTL and testbench
================================

# sevenseg_scan

Time-multiplexed scan controller for a bank of common-anode/cathode seven-segment digits that share one segment bus. Holds an N-digit BCD value, steps one digit enable at a time with a programmable dwell and anti-ghosting blank gap, and drives the shared segment lines through a single 4-bit-to-7-segment decoder. A double-buffered load handshake lets upstream logic post new values at any time, and the posted value takes effect at the next frame boundary with no tearing.

## Interface
- NDIGITS, 4, number of digits scanned (≥1)
- DWELL, 1000, clk cycles each digit is lit (≥1)
- BLANK, 16, clk cycles all digits are off between digits (≥0; 0 means no gap)
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- enable  in  1  scan run; 0 = display dark
- lz_blank_en  in  1  suppress leading zeros
- data_in  in  4*NDIGITS  BCD value; nibble i = digit i, digit 0 least significant
- load_valid  in  1  data_in is offered
- load_ready  out  1  pending buffer free
- segments  out  7  {a,b,c,d,e,f,g}, a = MSB, active-high
- digit_en  out  NDIGITS  one-hot active-high digit select
- frame_done  out  1  one-cycle pulse at end of each full frame

## Operation
- Registers: active (displayed value), pending plus pending_full flag, state, digit index idx, dwell counter cnt.
- Load: a transfer occurs when load_valid && load_ready. data_in is written to pending and pending_full is set. load_ready = !pending_full.
- Frame start is entry to SHOW with idx=0, either from IDLE or by wrapping from digit NDIGITS-1. If pending_full is set at frame start, pending is copied to active and pending_full is cleared in that cycle. A handshake in the same cycle is legal only when pending was empty, and its data goes to pending for the next frame.
- States:
  - IDLE: digit_en=0, segments=0. Go to SHOW (idx=0) when enable=1.
  - SHOW: digit_en=1<<idx and segments=decode(active[idx]). After DWELL cycles, go to BLANK, or go straight to the next digit if BLANK=0.
  - BLANK: digit_en=0, segments=0 for BLANK cycles. Then idx advances: idx=NDIGITS-1 wraps to 0, and that wrap is a frame start.
- Decode: 0 111_1110, 1 011_0000, 2 110_1101, 3 111_1001, 4 011_0011, 5 101_1011, 6 101_1111, 7 111_0000, 8 111_1111, 9 111_0011. Nibbles 10–15 give 000_0000.
- Leading-zero suppression: with lz_blank_en=1, every digit above the highest nonzero nibble of active shows segments=0. Its digit_en still follows the scan so brightness stays uniform. Digit 0 is never suppressed, so value 0 shows "0".
- enable=0 in any state: go to IDLE on the next cycle, clear idx and cnt, no frame_done. active and pending are kept.
- frame_done: pulses for one cycle on the last cycle of the final phase of digit NDIGITS-1. That phase is BLANK, or SHOW when BLANK=0.

## Timing
- Reset values (rst_n sampled low): state=IDLE, idx=0, cnt=0, active=0, pending_full=0, load_ready=1, digit_en=0, segments=0, frame_done=0.
- Reset mid-frame takes priority over everything else and discards pending.
- Outputs come from registered state, idx and active, with combinational decode only.
- The first SHOW cycle is the cycle after enable is first sampled high.
- Frame length is exactly NDIGITS*(DWELL+BLANK) cycles.
- Load-to-display latency: from the handshake, up to one frame plus one cycle.
- cnt width is $clog2(max(DWELL,BLANK,2)). cnt counts 0…DWELL-1 or 0…BLANK-1 and clears on every state change.

## Structure
- Package sevenseg_pkg holds:
  - state enum {IDLE, SHOW, BLANK}
  - DIGIT_W=4
  - SEG_BLANK=7'b000_0000
  - the segment patterns for 0–9
- Sub-module sevenseg_decode: combinational 4-bit to 7-bit decoder, one instance on the selected nibble.
- The top level holds the FSM, counters, double buffer and leading-zero logic.

## Test plan
Every scenario uses NDIGITS=4, DWELL=4, BLANK=2.
- Reset: hold rst_n=0 three cycles -> all outputs at reset values, load_ready=1. Release with enable=0 -> IDLE persists, outputs stay 0.
- Basic scan: load 0x1234, then enable=1 ->
  - digit_en=0001 with 011_0011 for 4 cycles, then 0 for 2 cycles
  - 0010 with 111_1001, 0100 with 110_1101, 1000 with 011_0000
  - frame_done on cycle 24, then the pattern repeats.
- Leading zeros: active=0x0050, lz_blank_en=1 ->
  - digits 3 and 2 show segments=0 while digit_en still steps
  - digit 1 shows 101_1011, digit 0 shows 111_1110
  - with lz_blank_en=0, digits 3 and 2 show 111_1110.
- Backpressure: mid-frame, load 0x1111 (accepted) then offer 0x2222 -> load_ready=0 and 0x2222 is held off. At the frame boundary 0x1111 becomes active and load_ready rises. 0x2222 is accepted and displays one frame later.
- enable and invalid nibbles: drop enable during digit 2 SHOW -> next cycle digit_en=0, segments=0, no frame_done. Re-enable -> restarts at digit 0. Separately, nibble 0xA displays 000_0000.
- Reset mid-frame: rst_n=0 during BLANK with pending_full=1 -> reset values next cycle, pending discarded, active=0.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared types and constants for the seven-segment scan controller
//
// Purpose: the scan FSM state type, the BCD digit width and the segment
// patterns ({a,b,c,d,e,f,g}, a = MSB, active-high) used by the decoder.
// Ports: none (package).

package sevenseg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_e;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    localparam logic [6:0] SEG_0 = 7'b111_1110;
    localparam logic [6:0] SEG_1 = 7'b011_0000;
    localparam logic [6:0] SEG_2 = 7'b110_1101;
    localparam logic [6:0] SEG_3 = 7'b111_1001;
    localparam logic [6:0] SEG_4 = 7'b011_0011;
    localparam logic [6:0] SEG_5 = 7'b101_1011;
    localparam logic [6:0] SEG_6 = 7'b101_1111;
    localparam logic [6:0] SEG_7 = 7'b111_0000;
    localparam logic [6:0] SEG_8 = 7'b111_1111;
    localparam logic [6:0] SEG_9 = 7'b111_0011;

endpackage

// File: rtl/sevenseg_decode.sv
// rtl/sevenseg_decode.sv - combinational BCD nibble to seven-segment decoder
//
// Purpose: maps one 4-bit digit to its segment pattern; non-BCD codes
// (10..15) produce an all-off pattern.
// Ports:
//   nibble_i  in   DIGIT_W  digit value
//   seg_o     out  7        {a,b,c,d,e,f,g}, active-high

module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  logic [DIGIT_W-1:0] nibble_i,
    output logic [6:0]         seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan.sv
// rtl/sevenseg_scan.sv - time-multiplexed seven-segment scan controller with double-buffered load
//
// Purpose: scans NDIGITS digits sharing one segment bus. Each digit is lit
// for DWELL cycles followed by a BLANK-cycle all-off gap. A value posted on
// the load handshake waits in a pending buffer and becomes the displayed
// value only at a frame boundary, so a frame never mixes two values.
// Ports:
//   clk          in   1           rising-edge clock
//   rst_n        in   1           synchronous active-low reset
//   enable       in   1           run the scan; low keeps the display dark
//   lz_blank_en  in   1           suppress leading zeros
//   data_in      in   4*NDIGITS   BCD value, nibble i = digit i
//   load_valid   in   1           data_in offered
//   load_ready   out  1           pending buffer free
//   segments     out  7           {a..g}, active-high
//   digit_en     out  NDIGITS     one-hot digit select
//   frame_done   out  1           pulse on the last cycle of a frame

module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int NDIGITS = 4,
    parameter int DWELL   = 1000,
    parameter int BLANK   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       lz_blank_en,
    input  logic [DIGIT_W*NDIGITS-1:0] data_in,
    input  logic                       load_valid,
    output logic                       load_ready,
    output logic [6:0]                 segments,
    output logic [NDIGITS-1:0]         digit_en,
    output logic                       frame_done
);

    localparam int VAL_W   = DIGIT_W * NDIGITS;
    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W   = $clog2((CNT_MAX > 2) ? CNT_MAX : 2);
    localparam int IDX_W   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    // Unused when BLANK is 0: the SHOW phase then hands over directly.
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NDIGITS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VAL_W-1:0]   active_q, active_d;
    logic [VAL_W-1:0]   pending_q, pending_d;
    logic               pending_full_q, pending_full_d;

    logic               show_last;
    logic               blank_last;
    logic               digit_done;
    logic               idx_wrap;
    logic [IDX_W-1:0]   idx_next;
    logic               frame_start;
    logic [DIGIT_W-1:0] cur_nibble;
    logic [6:0]         dec_seg;
    logic [NDIGITS-1:0] nz_at_or_above;
    logic               suppress;

    assign show_last  = (state_q == ST_SHOW)  && (cnt_q == DWELL_LAST);
    assign blank_last = (state_q == ST_BLANK) && (cnt_q == BLANK_LAST);
    // The final phase of a digit is its blank gap, or its lit phase when there is no gap.
    assign digit_done = (BLANK == 0) ? show_last : blank_last;
    assign idx_wrap   = (idx_q == IDX_LAST);
    assign idx_next   = idx_wrap ? '0 : idx_q + 1'b1;

    // Scan sequencing. frame_start marks the cycle whose edge enters SHOW at digit 0.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        frame_start = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_SHOW;
                    idx_d       = '0;
                    cnt_d       = '0;
                    frame_start = 1'b1;
                end
                ST_SHOW: begin
                    if (show_last) begin
                        cnt_d = '0;
                        if (BLANK == 0) begin
                            idx_d       = idx_next;
                            frame_start = idx_wrap;
                        end else begin
                            state_d = ST_BLANK;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (blank_last) begin
                        state_d     = ST_SHOW;
                        cnt_d       = '0;
                        idx_d       = idx_next;
                        frame_start = idx_wrap;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Double buffer. A full pending buffer blocks the handshake, so the
    // promotion to active and a new load can never collide in one cycle.
    always_comb begin
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        if (frame_start && pending_full_q) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
        end else if (load_valid && !pending_full_q) begin
            pending_d      = data_in;
            pending_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            cnt_q          <= '0;
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
        end
    end

    // nz_at_or_above[i] is set when digit i or any more significant digit is
    // nonzero; a digit without it is a leading zero.
    always_comb begin
        logic above;
        above          = 1'b0;
        nz_at_or_above = '0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            above             = above | (active_q[i*DIGIT_W +: DIGIT_W] != '0);
            nz_at_or_above[i] = above;
        end
    end

    assign cur_nibble = active_q[int'(idx_q)*DIGIT_W +: DIGIT_W];

    sevenseg_decode u_decode (
        .nibble_i (cur_nibble),
        .seg_o    (dec_seg)
    );

    // Digit 0 is always shown so an all-zero value still reads "0".
    assign suppress   = lz_blank_en && (idx_q != '0) && !nz_at_or_above[idx_q];

    assign load_ready = !pending_full_q;
    assign digit_en   = (state_q == ST_SHOW) ? (NDIGITS'(1) << idx_q) : '0;
    assign segments   = ((state_q == ST_SHOW) && !suppress) ? dec_seg : SEG_BLANK;
    assign frame_done = enable && digit_done && idx_wrap;

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb/tb_sevenseg_scan.sv - self-checking bench for sevenseg_scan

module tb_sevenseg_scan;

    localparam int ND    = 4;
    localparam int DW    = 4;
    localparam int BL    = 2;
    localparam int PH    = DW + BL;
    localparam int FRAME = ND * PH;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        lz_blank_en;
    logic [15:0] data_in;
    logic        load_valid;
    logic        load_ready;
    logic [6:0]  segments;
    logic [3:0]  digit_en;
    logic        frame_done;

    sevenseg_scan #(.NDIGITS(ND), .DWELL(DW), .BLANK(BL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .lz_blank_en (lz_blank_en),
        .data_in     (data_in),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .segments    (segments),
        .digit_en    (digit_en),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: position inside the frame timeline plus the two buffers.
    bit          m_run   = 1'b0;
    int          m_pos   = 0;
    logic [15:0] m_active  = '0;
    logic [15:0] m_pending = '0;
    bit          m_pfull = 1'b0;

    typedef struct {
        logic [15:0] value;
        logic        lz;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    } lz_vec_t;

    typedef struct {
        logic [3:0] den;
        logic [6:0] seg;
        logic       fd;
    } scan_vec_t;

    lz_vec_t   lz_tbl [7];
    scan_vec_t scan_tbl [FRAME];
    logic [6:0] basic_seg [4];

    function automatic logic [6:0] seg_of(int n);
        case (n)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1110011;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic [3:0] ed;
        logic [6:0] es;
        logic       efd;
        int d, nib;
        bit sup;
        ed  = '0;
        es  = '0;
        efd = 1'b0;
        if (m_run) begin
            d = m_pos / PH;
            if ((m_pos % PH) < DW) begin
                ed  = 4'(1 << d);
                nib = int'((m_active >> (4 * d)) & 16'hF);
                sup = lz_blank_en && (d != 0) && ((m_active >> (4 * d)) == 16'h0);
                es  = sup ? 7'b0 : seg_of(nib);
            end
            efd = enable && (m_pos == FRAME - 1);
        end
        chk("model_digit_en", 32'(digit_en), 32'(ed));
        chk("model_segments", 32'(segments), 32'(es));
        chk("model_frame_done", 32'(frame_done), 32'(efd));
        chk("model_load_ready", 32'(load_ready), 32'(!m_pfull));
    endtask

    task automatic model_step();
        bit fs;
        if (!rst_n) begin
            m_run = 0; m_pos = 0; m_active = '0; m_pfull = 0;
        end else begin
            fs = enable && (!m_run || m_pos == FRAME - 1);
            if (fs && m_pfull) begin
                m_active = m_pending;
                m_pfull  = 0;
            end else if (load_valid && !m_pfull) begin
                m_pending = data_in;
                m_pfull   = 1;
            end
            if (!enable) begin
                m_run = 0; m_pos = 0;
            end else if (!m_run) begin
                m_run = 1; m_pos = 0;
            end else begin
                m_pos = (m_pos + 1) % FRAME;
            end
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        #1;
        model_check();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Advances until frame_done is observed (bounded); leaves time before the edge.
    task automatic run_to_frame_end();
        int n;
        n = 0;
        #1;
        while (frame_done !== 1'b1 && n < 2 * FRAME) begin
            tick();
            #1;
            n++;
        end
        chk("frame_done_reached", 32'(frame_done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; enable = 0; lz_blank_en = 0; load_valid = 0; data_in = '0;

        basic_seg[0] = 7'b0110011; basic_seg[1] = 7'b1111001;
        basic_seg[2] = 7'b1101101; basic_seg[3] = 7'b0110000;
        for (int k = 0; k < FRAME; k++) begin
            scan_tbl[k].den = ((k % PH) < DW) ? 4'(1 << (k / PH)) : 4'b0;
            scan_tbl[k].seg = ((k % PH) < DW) ? basic_seg[k / PH] : 7'b0;
            scan_tbl[k].fd  = (k == FRAME - 1);
        end

        lz_tbl[0] = '{16'h0050, 1'b1, {7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110}};
        lz_tbl[1] = '{16'h0050, 1'b0, {7'b1111110, 7'b1111110, 7'b1011011, 7'b1111110}};
        lz_tbl[2] = '{16'h0000, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}};
        lz_tbl[3] = '{16'h0000, 1'b0, {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}};
        lz_tbl[4] = '{16'h00A7, 1'b0, {7'b1111110, 7'b1111110, 7'b0000000, 7'b1110000}};
        lz_tbl[5] = '{16'h00A7, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1110000}};
        lz_tbl[6] = '{16'h9806, 1'b1, {7'b1110011, 7'b1111111, 7'b1111110, 7'b1011111}};

        @(posedge clk);
        model_step();
        @(negedge clk);

        // Reset held, then released with enable low.
        repeat (3) begin
            #1;
            chk("reset_digit_en", 32'(digit_en), 32'd0);
            chk("reset_segments", 32'(segments), 32'd0);
            chk("reset_frame_done", 32'(frame_done), 32'd0);
            chk("reset_load_ready", 32'(load_ready), 32'd1);
            tick();
        end
        rst_n = 1;
        repeat (3) begin
            #1;
            chk("idle_digit_en", 32'(digit_en), 32'd0);
            chk("idle_segments", 32'(segments), 32'd0);
            tick();
        end

        // Basic scan of 0x1234 over two frames.
        data_in = 16'h1234; load_valid = 1;
        tick();
        load_valid = 0;
        #1 chk("load_ready_after_load", 32'(load_ready), 32'd0);
        enable = 1;
        tick();
        #1 chk("load_ready_after_promote", 32'(load_ready), 32'd1);
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < FRAME; k++) begin
                #1;
                chk("scan_digit_en", 32'(digit_en), 32'(scan_tbl[k].den));
                chk("scan_segments", 32'(segments), 32'(scan_tbl[k].seg));
                chk("scan_frame_done", 32'(frame_done), 32'(scan_tbl[k].fd));
                tick();
            end
        end

        // Backpressure: second offer waits until the frame boundary frees pending.
        repeat (8) tick();
        data_in = 16'h1111; load_valid = 1;
        tick();
        data_in = 16'h2222;
        #1 chk("bp_ready_low", 32'(load_ready), 32'd0);
        run_to_frame_end();
        tick();
        #1;
        chk("bp_first_value", 32'(segments), 32'(7'b0110000));
        chk("bp_ready_rises", 32'(load_ready), 32'd1);
        tick();
        load_valid = 0;
        #1 chk("bp_second_accepted", 32'(load_ready), 32'd0);
        run_to_frame_end();
        tick();
        #1 chk("bp_second_value", 32'(segments), 32'(7'b1101101));

        // Drop enable during digit 2 SHOW, then restart.
        repeat (12) tick();
        #1 chk("drop_at_digit2", 32'(digit_en), 32'b0100);
        enable = 0;
        #1 chk("drop_no_frame_done", 32'(frame_done), 32'd0);
        tick();
        #1;
        chk("drop_digit_en", 32'(digit_en), 32'd0);
        chk("drop_segments", 32'(segments), 32'd0);
        chk("drop_frame_done", 32'(frame_done), 32'd0);
        repeat (3) tick();
        enable = 1;
        tick();
        #1;
        chk("restart_digit0", 32'(digit_en), 32'b0001);
        chk("restart_segments", 32'(segments), 32'(7'b1101101));

        // Leading-zero and invalid-nibble vectors.
        for (int r = 0; r < 7; r++) begin
            enable = 0; data_in = lz_tbl[r].value; load_valid = 1;
            tick();
            load_valid = 0; lz_blank_en = lz_tbl[r].lz; enable = 1;
            tick();
            for (int d = 0; d < ND; d++) begin
                #1;
                chk("lz_digit_en", 32'(digit_en), 32'(1 << d));
                chk("lz_segments", 32'(segments), 32'(lz_tbl[r].segs[d*7 +: 7]));
                repeat (PH) tick();
            end
        end

        // Reset during BLANK with a pending value.
        lz_blank_en = 0;
        data_in = 16'h5555; load_valid = 1;
        tick();
        load_valid = 0;
        repeat (3) tick();
        #1;
        chk("mid_in_blank", 32'(digit_en), 32'd0);
        chk("mid_pending_full", 32'(load_ready), 32'd0);
        rst_n = 0;
        tick();
        #1;
        chk("mid_reset_digit_en", 32'(digit_en), 32'd0);
        chk("mid_reset_segments", 32'(segments), 32'd0);
        chk("mid_reset_load_ready", 32'(load_ready), 32'd1);
        rst_n = 1;
        tick();
        #1;
        chk("mid_reset_digit0", 32'(digit_en), 32'b0001);
        chk("mid_reset_discarded", 32'(segments), 32'(7'b1111110));

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            rst_n       = ($urandom % 300) != 0;
            enable      = ($urandom % 40) != 0;
            lz_blank_en = 1'($urandom % 2);
            load_valid  = ($urandom % 4) == 0;
            data_in     = 16'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
